// File: rtl/obi_bridge_mux.sv
// obi_bridge_mux: shares one OBI bridge port between NUM_CH host channels.
// Requests are arbitrated round-robin, and the address phase is held stable until
// it is granted. Each granted channel ID is pushed into an in-order FIFO, so that
// every rvalid_i can be routed back to the channel that issued the request.
// Optional feature: define OBI_BRIDGE_MUX_TIMEOUT_EN to enable the sticky
// response timeout (timeout_o). Without it, timeout_o is tied to 0.
module obi_bridge_mux #(
  parameter int NUM_CH          = 2,
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_CH-1:0]                    ch_req_i,
  input  logic [NUM_CH-1:0]                    ch_we_i,
  input  logic [NUM_CH*DW/8-1:0]               ch_be_i,
  input  logic [NUM_CH*AW-1:0]                 ch_addr_i,
  input  logic [NUM_CH*DW-1:0]                 ch_wdata_i,
  output logic [NUM_CH-1:0]                    ch_gnt_o,
  output logic [NUM_CH-1:0]                    ch_rvalid_o,
  output logic [DW-1:0]                        ch_rdata_o,
  output logic                                 req_o,
  output logic                                 we_o,
  output logic [DW/8-1:0]                      be_o,
  output logic [AW-1:0]                        addr_o,
  output logic [DW-1:0]                        wdata_o,
  input  logic                                 gnt_i,
  input  logic                                 rvalid_i,
  input  logic [DW-1:0]                        rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o,
  output logic                                 timeout_o
);

  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int BW    = DW / 8;

  logic [SEL_W-1:0]  rr_ptr_q, lock_ch_q, sel;
  logic              lock_q, sel_vld, sel_req;
  logic [SEL_W-1:0]  fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              fifo_full, fifo_empty, push, pop;
  logic              err_q;
  logic [SEL_W-1:0]  head;
  logic [2*NUM_CH-1:0] req_dbl;
  logic [NUM_CH-1:0] req_rot;
  int                sel_sum;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (occ_q == OCC_W'(MAX_OUTSTANDING));
  assign fifo_empty = (occ_q == '0);
  assign head       = fifo_q[rd_ptr_q];

  // Channel selection: a held (locked) channel wins; otherwise the first requester at or above rr_ptr_q
  always_comb begin
    req_dbl = {ch_req_i, ch_req_i} >> rr_ptr_q;
    req_rot = req_dbl[NUM_CH-1:0];
    sel_sum = 0;
    sel     = lock_ch_q;
    sel_vld = lock_q;
    if (!lock_q) begin
      for (int j = NUM_CH - 1; j >= 0; j--) begin
        if (req_rot[j]) begin
          sel_sum = int'(rr_ptr_q) + j;
          sel_vld = 1'b1;
        end
      end
      if (sel_sum >= NUM_CH) sel_sum = sel_sum - NUM_CH;
      sel = SEL_W'(sel_sum);
    end
  end

  // Request mux toward the bridge; fields read as zero when nothing is selected
  always_comb begin
    sel_req = 1'b0;
    we_o    = 1'b0;
    be_o    = '0;
    addr_o  = '0;
    wdata_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_vld && sel == SEL_W'(c)) begin
        sel_req = ch_req_i[c];
        we_o    = ch_we_i[c];
        be_o    = ch_be_i[c*BW +: BW];
        addr_o  = ch_addr_i[c*AW +: AW];
        wdata_o = ch_wdata_i[c*DW +: DW];
      end
    end
    req_o = sel_req && !fifo_full;
  end

  assign push = req_o && gnt_i;
  assign pop  = rvalid_i && !fifo_empty;

  // Grant and response routing back to the channels
  always_comb begin
    ch_gnt_o    = '0;
    ch_rvalid_o = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_gnt_o[c]    = push && (sel == SEL_W'(c));
      ch_rvalid_o[c] = pop && (head == SEL_W'(c));
    end
  end

  assign ch_rdata_o = rdata_i;

  // Occupancy next state; a simultaneous push and pop leaves it unchanged
  always_comb begin
    occ_d = occ_q;
    if (push && !pop)      occ_d = occ_q + 1'b1;
    else if (!push && pop) occ_d = occ_q - 1'b1;
  end

  // Arbiter pointer, address-phase lock, ID FIFO and the stray-response flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      err_q     <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
    end else begin
      occ_q <= occ_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
        rr_ptr_q         <= (sel == SEL_W'(NUM_CH - 1)) ? '0 : sel + 1'b1;
        lock_q           <= 1'b0;
      end else if (req_o) begin
        lock_q    <= 1'b1;
        lock_ch_q <= sel;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  assign outstanding_o = occ_q;
  assign err_o         = err_q;

`ifdef OBI_BRIDGE_MUX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            timeout_q;

  // Response watchdog: counts while IDs are in flight, restarts on every response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (pop || fifo_empty)                        to_cnt_q <= '0;
      else if (to_cnt_q != TO_W'(TIMEOUT_CYCLES))  to_cnt_q <= to_cnt_q + 1'b1;
      if (to_cnt_q == TO_W'(TIMEOUT_CYCLES))        timeout_q <= 1'b1;
    end
  end

  assign timeout_o = timeout_q;
`else
  // The comparison is always false; it only keeps TIMEOUT_CYCLES referenced in this build
  assign timeout_o = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_obi_bridge_mux.sv
// Bench for obi_bridge_mux (NUM_CH=2, MAX_OUTSTANDING=4, TIMEOUT_CYCLES=16).
// It steps through a stimulus table, and a scoreboard queue predicts response routing and occupancy.
module tb_obi_bridge_mux;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'hAAAA_0000;
  localparam logic [31:0] W1 = 32'hBBBB_1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  ch_req_i, ch_we_i, ch_gnt_o, ch_rvalid_o;
  logic [7:0]  ch_be_i;
  logic [63:0] ch_addr_i, ch_wdata_i;
  logic [31:0] ch_rdata_o, addr_o, wdata_o, rdata_i;
  logic        req_o, we_o, gnt_i, rvalid_i, err_o, timeout_o;
  logic [3:0]  be_o;
  logic [2:0]  outstanding_o;

  always #5 clk = ~clk;

  obi_bridge_mux #(.NUM_CH(2), .AW(32), .DW(32), .MAX_OUTSTANDING(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_i(ch_req_i), .ch_we_i(ch_we_i), .ch_be_i(ch_be_i),
    .ch_addr_i(ch_addr_i), .ch_wdata_i(ch_wdata_i),
    .ch_gnt_o(ch_gnt_o), .ch_rvalid_o(ch_rvalid_o), .ch_rdata_o(ch_rdata_o),
    .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t vecs[$];
  int   sb[$];
  logic err_m;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic [1:0] r, logic g, logic rv, logic er,
                              logic [31:0] ea, logic [1:0] eg);
    vec_t t;
    t.req = r; t.gnt = g; t.rv = rv; t.exp_req = er; t.exp_addr = ea; t.exp_gnt = eg;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then update the scoreboard
  task automatic step(input vec_t t);
    logic [1:0]  exp_rv;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    ch_req_i = t.req; gnt_i = t.gnt; rvalid_i = t.rv; rdata_i = $urandom;
    @(negedge clk);
    exp_rv = (t.rv && sb.size() > 0) ? (2'b01 << sb[0]) : 2'b00;
    exp_we = 1'b0; exp_be = 4'h0; exp_wd = 32'h0;
    if (t.exp_addr == A0) begin exp_we = 1'b1; exp_be = 4'h3; exp_wd = W0; end
    if (t.exp_addr == A1) begin exp_we = 1'b0; exp_be = 4'hC; exp_wd = W1; end
    chk("req_o", {31'b0, req_o}, {31'b0, t.exp_req});
    chk("addr_o", addr_o, t.exp_addr);
    chk("we_o", {31'b0, we_o}, {31'b0, exp_we});
    chk("be_o", {28'b0, be_o}, {28'b0, exp_be});
    chk("wdata_o", wdata_o, exp_wd);
    chk("ch_gnt_o", {30'b0, ch_gnt_o}, {30'b0, t.exp_gnt});
    chk("ch_rvalid_o", {30'b0, ch_rvalid_o}, {30'b0, exp_rv});
    chk("ch_rdata_o", ch_rdata_o, rdata_i);
    chk("outstanding_o", {29'b0, outstanding_o}, sb.size());
    chk("err_o", {31'b0, err_o}, {31'b0, err_m});
    if (t.rv) begin
      if (sb.size() > 0) void'(sb.pop_front());
      else err_m = 1'b1;
    end
    if (t.exp_gnt != 2'b00) sb.push_back(t.exp_gnt[1] ? 1 : 0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ch_req_i = 2'b00; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    @(negedge clk);
    chk("rst outstanding_o", {29'b0, outstanding_o}, 32'd0);
    chk("rst err_o", {31'b0, err_o}, 32'd0);
    chk("rst timeout_o", {31'b0, timeout_o}, 32'd0);
    chk("rst ch_rvalid_o", {30'b0, ch_rvalid_o}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    err_m = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) step(vecs[i]);
  endtask

  logic exp_to;
  int   n_single;

  initial begin
    ch_we_i = 2'b01; ch_be_i = {4'hC, 4'h3};
    ch_addr_i = {A1, A0}; ch_wdata_i = {W1, W0};
    err_m = 1'b0;

    // single channel write, response two cycles later
    vecs.push_back(mk(2'b01, 1, 0, 1, A0, 2'b01));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    n_single = vecs.size();
    // fairness: alternating grants, responses one cycle behind
    vecs.push_back(mk(2'b11, 1, 0, 1, A0, 2'b01));
    vecs.push_back(mk(2'b11, 1, 1, 1, A1, 2'b10));
    vecs.push_back(mk(2'b11, 1, 1, 1, A0, 2'b01));
    vecs.push_back(mk(2'b11, 1, 1, 1, A1, 2'b10));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    // lock: ch1 presented without grant stays selected while ch0 waits
    vecs.push_back(mk(2'b10, 0, 0, 1, A1, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 1, A1, 2'b00));
    vecs.push_back(mk(2'b11, 0, 0, 1, A1, 2'b00));
    vecs.push_back(mk(2'b11, 1, 0, 1, A1, 2'b10));
    vecs.push_back(mk(2'b11, 1, 0, 1, A0, 2'b01));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    // full: four grants, then blocked even with a same-cycle pop
    vecs.push_back(mk(2'b11, 1, 0, 1, A1, 2'b10));
    vecs.push_back(mk(2'b11, 1, 0, 1, A0, 2'b01));
    vecs.push_back(mk(2'b11, 1, 0, 1, A1, 2'b10));
    vecs.push_back(mk(2'b11, 1, 0, 1, A0, 2'b01));
    vecs.push_back(mk(2'b11, 1, 0, 0, A1, 2'b00));
    vecs.push_back(mk(2'b11, 1, 1, 0, A1, 2'b00));
    vecs.push_back(mk(2'b11, 1, 0, 1, A1, 2'b10));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    // stray response with the FIFO empty
    vecs.push_back(mk(2'b00, 0, 1, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));
    vecs.push_back(mk(2'b00, 0, 0, 0, 0,  2'b00));

    do_reset();
    run(0, n_single);
    do_reset();
    run(n_single, vecs.size());

    // reset with one ID in flight: the late response becomes a stray
    step(mk(2'b01, 1, 0, 1, A0, 2'b01));
    step(mk(2'b00, 0, 0, 0, 0,  2'b00));
    do_reset();
    step(mk(2'b00, 0, 1, 0, 0,  2'b00));
    step(mk(2'b00, 0, 0, 0, 0,  2'b00));

    // response timeout with one request left unanswered
    do_reset();
    step(mk(2'b01, 1, 0, 1, A0, 2'b01));
    for (int i = 0; i < 9; i++) step(mk(2'b00, 0, 0, 0, 0, 2'b00));
    chk("timeout_o early", {31'b0, timeout_o}, 32'd0);
    for (int i = 0; i < 11; i++) step(mk(2'b00, 0, 0, 0, 0, 2'b00));
`ifdef OBI_BRIDGE_MUX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    chk("timeout_o late", {31'b0, timeout_o}, {31'b0, exp_to});
    step(mk(2'b00, 0, 1, 0, 0, 2'b00));
    step(mk(2'b00, 0, 0, 0, 0, 2'b00));
    chk("timeout_o sticky", {31'b0, timeout_o}, {31'b0, exp_to});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_bridge_mux.md
# obi_bridge_mux

Parametrised N-channel successor to the single-channel testbench OBI bridge port. It lets several stimulus agents (DPI drivers, directed sequences, a DMA model) share the one `req/we/be/addr/wdata/gnt/rvalid/rdata` bridge into the testharness. It arbitrates requests round-robin and tracks outstanding transactions in an in-order ID FIFO. Each `rvalid` is routed back to the channel that issued the request. Synthesizable; it sits between the agents and the testharness bridge port.

## Interface
- `NUM_CH`, 2: number of host channels (≥1).
- `AW`, 32: address width.
- `DW`, 32: data width (multiple of 8).
- `MAX_OUTSTANDING`, 4: depth of the outstanding-ID FIFO (≥1).
- `TIMEOUT_CYCLES`, 1024: response timeout; used only with the timeout feature.
- Reset is `rst_n`, asynchronous, active-low. The clock is `clk`.
- `clk` in 1 clock
- `rst_n` in 1 async active-low reset
- `ch_req_i` in NUM_CH per-channel request
- `ch_we_i` in NUM_CH per-channel write enable
- `ch_be_i` in NUM_CH*DW/8 packed byte enables
- `ch_addr_i` in NUM_CH*AW packed addresses
- `ch_wdata_i` in NUM_CH*DW packed write data
- `ch_gnt_o` out NUM_CH per-channel grant, one-hot or zero
- `ch_rvalid_o` out NUM_CH per-channel response valid, one-hot or zero
- `ch_rdata_o` out DW response data, broadcast to all channels
- `req_o`, `we_o`, `be_o`, `addr_o`, `wdata_o` out 1/1/DW/8/AW/DW bridge request
- `gnt_i`, `rvalid_i`, `rdata_i` in 1/1/DW bridge response
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1) current FIFO occupancy
- `err_o` out 1 sticky: `rvalid_i` arrived with the FIFO empty
- `timeout_o` out 1 sticky: response timeout

## Operation
- **State:**
  - `rr_ptr_q` holds the highest-priority channel; reset value 0.
  - `lock_q` and `lock_ch_q` hold the address-phase lock; reset value 0.
  - The ID FIFO stores MAX_OUTSTANDING entries of $clog2(NUM_CH) bits (1 bit when NUM_CH=1). It resets empty.
  - Sticky flags reset to 0.
- **Selection:**
  - If `lock_q` is set, the selected channel is `lock_ch_q`.
  - Otherwise the selected channel is the first requesting channel found scanning upward from `rr_ptr_q`, wrapping modulo NUM_CH.
- **Request path (combinational):**
  - `req_o` = selected channel's `ch_req_i` && !fifo_full.
  - `we_o`, `be_o`, `addr_o` and `wdata_o` mux the selected channel's fields. They are 0 when no channel is selected.
  - `ch_gnt_o[sel]` = `gnt_i` && `req_o`. All other bits of `ch_gnt_o` are 0.
- **Lock (OBI address-phase stability):**
  - On `req_o` && !`gnt_i`: set `lock_q` and latch `lock_ch_q` = sel.
  - On `req_o` && `gnt_i`: clear `lock_q`.
  - A channel that has been presented is never switched away from before its grant.
- **Handshake** (`req_o` && `gnt_i`):
  - Push sel into the FIFO.
  - Set `rr_ptr_q` to (sel+1) mod NUM_CH.
- **Response:**
  - On `rvalid_i` with the FIFO non-empty: pop the FIFO and assert `ch_rvalid_o[head]`.
  - `ch_rdata_o` = `rdata_i` at all times.
  - On `rvalid_i` with the FIFO empty: set `err_o` and drive no `ch_rvalid_o` bit.
- **Full:**
  - fifo_full is occupancy == MAX_OUTSTANDING and blocks `req_o`, even if a pop occurs in the same cycle.
  - Full cannot arise while `lock_q` is set.
- **Push and pop in the same cycle:** occupancy is unchanged.
- **Reset mid-operation:** all state clears immediately, in-flight IDs are discarded, and responses arriving after reset set `err_o`.

## Timing
- Request, grant and rvalid routing are zero-latency (combinational) through the block. No added cycles.
- FIFO occupancy and `outstanding_o` update on the clock edge after the handshake or response.
- The sticky flags assert on the clock edge after the triggering cycle. They clear only on reset.
- With `gnt_i` held at 1, back-to-back grants are one per cycle, rotating across all requesting channels.
- Occupancy wraps correctly via pointer arithmetic modulo MAX_OUTSTANDING. Non-power-of-two depth is supported.

## Configuration
- **`OBI_BRIDGE_MUX_TIMEOUT_EN` defined:**
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits increments each cycle while the FIFO is non-empty.
  - It clears on any pop and holds at 0 while the FIFO is empty.
  - When it reaches TIMEOUT_CYCLES, `timeout_o` sets (sticky) and the counter saturates.
- **Not defined:** the counter is absent and `timeout_o` is tied to 0.

## Test plan
- Single channel, NUM_CH=2: ch0 write to 0x0000_1000 with `gnt_i`=1 → `req_o`=1 and `addr_o`=0x1000 the same cycle; `outstanding_o`=1. `rvalid_i` 2 cycles later → `ch_rvalid_o`=2'b01 and `outstanding_o`=0.
- Fairness: ch0 and ch1 request continuously with `gnt_i`=1 and rvalid 1 cycle after each grant → grants alternate ch0, ch1, ch0, ch1. Responses are routed 01, 10, 01, 10.
- Lock: ch1 presents with `gnt_i`=0 for 3 cycles while ch0 also requests → `addr_o` stays ch1's address. Grant in cycle 4 goes to ch1, and ch0 is granted next.
- Full, MAX_OUTSTANDING=4: 4 grants with no rvalid → `outstanding_o`=4 and `req_o`=0 despite pending requests. One `rvalid_i` → `req_o` is re-enabled the following cycle.
- Stray response: `rvalid_i`=1 with the FIFO empty → `err_o`=1 next cycle and stays 1; `ch_rvalid_o`=0.
- Timeout, macro defined, TIMEOUT_CYCLES=16: one grant and no rvalid → `timeout_o`=1 after 16 cycles. Rerun without the macro → `timeout_o` stays 0.
